// File: rtl/vrf_pkg.sv
// vrf_pkg: shared VRF read-request field widths and request struct
package vrf_pkg;
  localparam int VRF_VS_W  = 5;
  localparam int VRF_SRC_W = 2;
  localparam int VRF_OFS_W = 9;
  localparam int VRF_IDX_W = 3;
  typedef struct packed {
    logic [VRF_VS_W-1:0]  vs;
    logic [VRF_SRC_W-1:0] readSource;
    logic [VRF_OFS_W-1:0] offset;
    logic [VRF_IDX_W-1:0] instructionIndex;
  } vrf_read_req_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set bit of valid_i searching from start_i upward with wrap
//   valid_i  candidate vector
//   start_i  first index searched
//   onehot_o selected candidate, idx_o its index, any_o a candidate exists
module rr_priority_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // Scan from the farthest offset down so the nearest valid index overwrites last.
  // Wrap is an explicit compare so non-power-of-two N works.
  always_comb begin
    int j;
    j = 0;
    onehot_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start_i) + k;
      j = (j >= N) ? j - N : j;
      if (valid_i[j]) begin
        onehot_o = '0;
        onehot_o[j] = 1'b1;
        idx_o = IW'(j);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vrf_read_port_arbiter.sv
// vrf_read_port_arbiter: round-robin arbiter with starvation override sharing one VRF read port
//   clock/reset                 clock, async active-low reset
//   io_in_valid/io_in_ready     per-requester handshake (ready one-hot or zero)
//   io_in_bits_*                packed per-requester request fields
//   io_out_ready/io_out_valid   registered request handshake toward the VRF
//   io_out_bits_*, io_out_grantIdx  registered winner fields and its requester index
module vrf_read_port_arbiter
  import vrf_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int STARVE_LIMIT = 7,
  localparam int IW           = $clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             io_in_valid,
  output logic [NUM_REQ-1:0]             io_in_ready,
  input  logic [NUM_REQ*VRF_VS_W-1:0]    io_in_bits_vs,
  input  logic [NUM_REQ*VRF_SRC_W-1:0]   io_in_bits_readSource,
  input  logic [NUM_REQ*VRF_OFS_W-1:0]   io_in_bits_offset,
  input  logic [NUM_REQ*VRF_IDX_W-1:0]   io_in_bits_instructionIndex,
  input  logic                           io_out_ready,
  output logic                           io_out_valid,
  output logic [VRF_VS_W-1:0]            io_out_bits_vs,
  output logic [VRF_SRC_W-1:0]           io_out_bits_readSource,
  output logic [VRF_OFS_W-1:0]           io_out_bits_offset,
  output logic [VRF_IDX_W-1:0]           io_out_bits_instructionIndex,
  output logic [IW-1:0]                  io_out_grantIdx
);
  vrf_read_req_t       req [NUM_REQ];
  vrf_read_req_t       out_q;
  logic [3:0]          wait_q [NUM_REQ];
  logic [NUM_REQ-1:0]  starving;
  logic                valid_q;
  logic [IW-1:0]       grant_q, rr_q, rr_d;
  logic [NUM_REQ-1:0]  st_oh, rr_oh, win_oh;
  logic [IW-1:0]       st_idx, rr_idx, win;
  logic                st_any, rr_any, accept, fire;
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = '{vs:               io_in_bits_vs[VRF_VS_W*i +: VRF_VS_W],
                 readSource:       io_in_bits_readSource[VRF_SRC_W*i +: VRF_SRC_W],
                 offset:           io_in_bits_offset[VRF_OFS_W*i +: VRF_OFS_W],
                 instructionIndex: io_in_bits_instructionIndex[VRF_IDX_W*i +: VRF_IDX_W]};
      starving[i] = io_in_valid[i] && (wait_q[i] == 4'(STARVE_LIMIT));
    end
  end
  rr_priority_pick #(.N(NUM_REQ)) u_starve_pick (
    .valid_i(starving), .start_i('0), .onehot_o(st_oh), .idx_o(st_idx), .any_o(st_any)
  );
  rr_priority_pick #(.N(NUM_REQ)) u_rr_pick (
    .valid_i(io_in_valid), .start_i(rr_q), .onehot_o(rr_oh), .idx_o(rr_idx), .any_o(rr_any)
  );
  // Reset gates accept so no requester sees ready while reset is asserted.
  assign accept      = reset && (!valid_q || io_out_ready);
  assign win         = st_any ? st_idx : rr_idx;
  assign win_oh      = st_any ? st_oh : rr_oh;
  assign fire        = accept && rr_any;
  assign io_in_ready = accept ? win_oh : '0;
  assign rr_d        = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      if (accept) valid_q <= rr_any;
      if (fire) begin
        out_q   <= req[win];
        grant_q <= win;
        rr_q    <= rr_d;
      end
      for (int i = 0; i < NUM_REQ; i++)
        wait_q[i] <= (!io_in_valid[i] || io_in_ready[i]) ? 4'd0 :
                     (wait_q[i] == 4'(STARVE_LIMIT)) ? wait_q[i] : wait_q[i] + 4'd1;
    end
  end
  assign io_out_valid                 = valid_q;
  assign io_out_bits_vs               = out_q.vs;
  assign io_out_bits_readSource       = out_q.readSource;
  assign io_out_bits_offset           = out_q.offset;
  assign io_out_bits_instructionIndex = out_q.instructionIndex;
  assign io_out_grantIdx              = grant_q;
endmodule

// File: tb/tb_vrf_read_port_arbiter.sv
// tb_vrf_read_port_arbiter: scoreboard bench for the VRF read-port arbiter
module tb_vrf_read_port_arbiter;
  localparam int N = 4, LIM = 3;
  logic clock = 1'b0, reset = 1'b0;
  logic [N-1:0] in_valid, in_ready;
  logic [N*5-1:0] in_vs;
  logic [N*2-1:0] in_src;
  logic [N*9-1:0] in_ofs;
  logic [N*3-1:0] in_idx;
  logic out_ready, out_valid;
  logic [4:0] out_vs;
  logic [1:0] out_src, out_gidx;
  logic [8:0] out_ofs;
  logic [2:0] out_idx;
  int errs = 0, checks = 0;
  logic [20:0] sb[$];
  logic [20:0] held;
  int rr_m;
  int wait_m[N];
  bit ov_m;
  logic [N-1:0] fired;
  vrf_read_port_arbiter #(.NUM_REQ(N), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready),
    .io_in_bits_vs(in_vs), .io_in_bits_readSource(in_src),
    .io_in_bits_offset(in_ofs), .io_in_bits_instructionIndex(in_idx),
    .io_out_ready(out_ready), .io_out_valid(out_valid),
    .io_out_bits_vs(out_vs), .io_out_bits_readSource(out_src),
    .io_out_bits_offset(out_ofs), .io_out_bits_instructionIndex(out_idx),
    .io_out_grantIdx(out_gidx)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [20:0] out_word();
    return {out_vs, out_src, out_ofs, out_idx, out_gidx};
  endfunction
  task automatic set_req(input int i, input bit v, input logic [4:0] vs, input logic [1:0] src,
                         input logic [8:0] ofs, input logic [2:0] idx);
    in_valid[i] = v;
    in_vs[5*i +: 5] = vs;
    in_src[2*i +: 2] = src;
    in_ofs[9*i +: 9] = ofs;
    in_idx[3*i +: 3] = idx;
  endtask
  task automatic model_reset();
    rr_m = 0;
    for (int i = 0; i < N; i++) wait_m[i] = 0;
    ov_m = 1'b0;
    sb.delete();
    held = '0;
    fired = '0;
  endtask
  // One clock: predict the winner, check ready, push the expected output,
  // then after the edge pop and compare (or check idle / hold).
  task automatic tick();
    int w;
    bit acc;
    logic [20:0] e;
    w = -1;
    #2;
    for (int i = 0; i < N; i++)
      if (w < 0 && in_valid[i] && wait_m[i] == LIM) w = i;
    for (int k = 0; k < N; k++)
      if (w < 0 && in_valid[(rr_m + k) % N]) w = (rr_m + k) % N;
    acc = !ov_m || out_ready;
    fired = (acc && w >= 0) ? 4'(1 << w) : 4'b0;
    chk("in_ready", 32'(in_ready), 32'(fired));
    if (fired != 0)
      sb.push_back({in_vs[5*w +: 5], in_src[2*w +: 2], in_ofs[9*w +: 9], in_idx[3*w +: 3], 2'(w)});
    for (int i = 0; i < N; i++)
      wait_m[i] = (!in_valid[i] || fired[i]) ? 0 : (wait_m[i] < LIM ? wait_m[i] + 1 : LIM);
    if (acc) ov_m = (w >= 0);
    if (fired != 0) rr_m = (w + 1) % N;
    @(posedge clock);
    #1;
    if (fired != 0) begin
      e = sb.pop_front();
      held = e;
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_bits", 32'(out_word()), 32'(e));
    end else if (acc) begin
      chk("out_idle", 32'(out_valid), 32'd0);
    end else begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_bits", 32'(out_word()), 32'(held));
    end
    @(negedge clock);
  endtask
  initial begin
    in_valid = '0; in_vs = '0; in_src = '0; in_ofs = '0; in_idx = '0;
    out_ready = 1'b0;
    model_reset();
    in_valid = 4'b1111;
    repeat (2) @(negedge clock);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bits", 32'(out_word()), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    // Round robin, all valid, drain every cycle
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 2'(i), 9'(100 + i), 3'(i));
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rr_seq", 32'(out_gidx), 32'(c % N));
    end
    // Backpressure with req1 behind a full slot
    in_valid = '0;
    tick();
    set_req(1, 1'b1, 5'd4, 2'd2, 9'd200, 3'd1);
    out_ready = 1'b0;
    tick();
    set_req(1, 1'b1, 5'd9, 2'd1, 9'd300, 3'd5);
    repeat (5) tick();
    out_ready = 1'b1;
    tick();
    chk("bp_grant", 32'(out_gidx), 32'd1);
    chk("bp_vs", 32'(out_vs), 32'd9);
    // Starvation: rr_ptr driven to 0 by a req3 grant, then req2 waits out the limit
    in_valid = '0;
    tick();
    set_req(3, 1'b1, 5'd1, 2'd1, 9'd1, 3'd1);
    out_ready = 1'b0;
    tick();
    in_valid = '0;
    set_req(2, 1'b1, 5'd17, 2'd3, 9'd77, 3'd6);
    repeat (3) tick();
    set_req(0, 1'b1, 5'd2, 2'd0, 9'd5, 3'd2);
    out_ready = 1'b1;
    tick();
    chk("starve_win", 32'(out_gidx), 32'd2);
    // Wrap from rr_ptr=3 with extreme field values
    in_valid[2] = 1'b0;
    set_req(3, 1'b1, 5'd31, 2'd3, 9'd511, 3'd7);
    tick();
    chk("wrap_first", 32'(out_gidx), 32'd3);
    chk("wrap_vs", 32'(out_vs), 32'd31);
    chk("wrap_ofs", 32'(out_ofs), 32'd511);
    chk("wrap_idx", 32'(out_idx), 32'd7);
    in_valid[3] = 1'b0;
    tick();
    chk("wrap_second", 32'(out_gidx), 32'd0);
    // Idle gap: single request yields one valid cycle
    in_valid = '0;
    tick();
    set_req(1, 1'b1, 5'd12, 2'd1, 9'd42, 3'd3);
    tick();
    chk("gap_on", 32'(out_valid), 32'd1);
    in_valid = '0;
    tick();
    chk("gap_off", 32'(out_valid), 32'd0);
    // Random traffic honouring valid/bits hold until ready
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < N; i++)
        if (fired[i] || !in_valid[i]) begin
          if ($urandom_range(2) != 0)
            set_req(i, 1'b1, 5'($urandom), 2'($urandom), 9'($urandom), 3'($urandom));
          else
            in_valid[i] = 1'b0;
        end
      out_ready = ($urandom_range(3) != 0);
      tick();
    end
    // Reset mid-traffic with a held request
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 20), 2'(i), 9'(400 + i), 3'(7 - i));
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    in_valid = 4'b1010;
    out_ready = 1'b1;
    tick();
    chk("rst_first", 32'(out_gidx), 32'd1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
